// File: rtl/latch_sequencer.sv
// latch_sequencer: CLE/ALE + WE# latch-cycle sequencer for an ONFI NAND pad ring.
// Drives a burst of 1..MAX_CYCLES latch cycles per request with programmable
// WE# low, WE# high and latch-hold timing. All outputs are registered.
module latch_sequencer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned MAX_CYCLES = 5,
  parameter int unsigned T_WP       = 2,
  parameter int unsigned T_WH       = 2,
  parameter int unsigned T_CLH      = 2,
  parameter int unsigned T_ALH      = 2,
  localparam int unsigned CW        = $clog2(MAX_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              activate,
  input  logic              mode,
  input  logic [CW-1:0]     n_cycles,
  input  logic              abort,
  input  logic [DATA_W-1:0] data_in,
  output logic [CW-1:0]     byte_idx,
  output logic              cle,
  output logic              ale,
  output logic              we_n,
  output logic [DATA_W-1:0] io_out,
  output logic              io_oe,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  // Counter is sized for the largest timing parameter.
  localparam int unsigned T_MAX_A = (T_WP  > T_WH)    ? T_WP  : T_WH;
  localparam int unsigned T_MAX_B = (T_CLH > T_ALH)   ? T_CLH : T_ALH;
  localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned CNT_W   = $clog2(T_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WE_LOW  = 2'd1,
    WE_HIGH = 2'd2,
    HOLD    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]       len_q, len_d;
  logic                mode_q, mode_d;
  logic [CW-1:0]       byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0]   io_out_q, io_out_d;
  logic                cle_q, cle_d;
  logic                ale_q, ale_d;
  logic                we_n_q, we_n_d;
  logic                io_oe_q, io_oe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;

  logic                cnt_exp;
  logic                last_byte;
  logic                go_idle;

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      mode_q     <= 1'b0;
      byte_idx_q <= '0;
      io_out_q   <= '0;
      cle_q      <= 1'b0;
      ale_q      <= 1'b0;
      we_n_q     <= 1'b1;
      io_oe_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      mode_q     <= mode_d;
      byte_idx_q <= byte_idx_d;
      io_out_q   <= io_out_d;
      cle_q      <= cle_d;
      ale_q      <= ale_d;
      we_n_q     <= we_n_d;
      io_oe_q    <= io_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  // Next state and next registered outputs; abort overrides counter expiry.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    mode_d     = mode_q;
    byte_idx_d = byte_idx_q;
    io_out_d   = io_out_q;
    cle_d      = cle_q;
    ale_d      = ale_q;
    we_n_d     = we_n_q;
    io_oe_d    = io_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    go_idle    = 1'b0;
    cnt_exp    = (cnt_q == CNT_W'(1));
    last_byte  = (byte_idx_q == (len_q - CW'(1)));

    unique case (state_q)
      IDLE: begin
        if (activate && (n_cycles != '0)) begin
          state_d    = WE_LOW;
          cnt_d      = CNT_W'(T_WP);
          mode_d     = mode;
          len_d      = (n_cycles > CW'(MAX_CYCLES)) ? CW'(MAX_CYCLES) : n_cycles;
          byte_idx_d = '0;
          io_out_d   = data_in;
          cle_d      = ~mode;
          ale_d      = mode;
          we_n_d     = 1'b0;
          io_oe_d    = 1'b1;
          busy_d     = 1'b1;
        end
      end
      WE_LOW: begin
        if (cnt_exp) begin
          we_n_d = 1'b1;
          if (last_byte) begin
            state_d = HOLD;
            cnt_d   = mode_q ? CNT_W'(T_ALH) : CNT_W'(T_CLH);
          end else begin
            state_d    = WE_HIGH;
            cnt_d      = CNT_W'(T_WH);
            byte_idx_d = byte_idx_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WE_HIGH: begin
        if (cnt_exp) begin
          state_d  = WE_LOW;
          cnt_d    = CNT_W'(T_WP);
          io_out_d = data_in;
          we_n_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_exp) begin
          go_idle = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        go_idle = 1'b1;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      go_idle   = 1'b1;
      done_d    = 1'b0;
      aborted_d = 1'b1;
    end

    if (go_idle) begin
      state_d    = IDLE;
      cnt_d      = '0;
      byte_idx_d = '0;
      io_out_d   = '0;
      cle_d      = 1'b0;
      ale_d      = 1'b0;
      we_n_d     = 1'b1;
      io_oe_d    = 1'b0;
      busy_d     = 1'b0;
    end
  end

  assign byte_idx = byte_idx_q;
  assign cle      = cle_q;
  assign ale      = ale_q;
  assign we_n     = we_n_q;
  assign io_out   = io_out_q;
  assign io_oe    = io_oe_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;

endmodule

// File: tb/tb_latch_sequencer.sv
// Bench for latch_sequencer: two instances (default timing and a fast/long-hold
// variant) checked every cycle against a timeline model built per request.
module tb_latch_sequencer;

  typedef struct packed {
    logic       cle;
    logic       ale;
    logic       we_n;
    logic       io_oe;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [2:0] idx;
    logic [7:0] io;
  } obs_t;

  logic clk;
  logic nreset;

  logic       act0, mode0, abort0;
  logic [2:0] ncy0;
  logic [7:0] din0;
  logic [2:0] idx0;
  logic       cle0, ale0, we_n0, oe0, busy0, done0, abt0;
  logic [7:0] io0;

  logic       act1, mode1, abort1;
  logic [2:0] ncy1;
  logic [7:0] din1;
  logic [2:0] idx1;
  logic       cle1, ale1, we_n1, oe1, busy1, done1, abt1;
  logic [7:0] io1;

  logic [7:0] bytes0 [8];
  logic [7:0] bytes1 [8];

  int checks;
  int failures;

  obs_t exp0 [$];
  obs_t exp1 [$];

  int busy_run [2];
  int pulse_run [2];
  int last_busy [2];
  int last_pulses [2];
  int done_cnt [2];
  int abt_cnt [2];
  logic prev_busy [2];
  logic prev_we_n [2];

  // Caller-side byte mux.
  assign din0 = bytes0[idx0];
  assign din1 = bytes1[idx1];

  latch_sequencer #(
    .DATA_W(8), .MAX_CYCLES(5), .T_WP(2), .T_WH(2), .T_CLH(2), .T_ALH(2)
  ) u_dut0 (
    .clk(clk), .nreset(nreset), .activate(act0), .mode(mode0), .n_cycles(ncy0),
    .abort(abort0), .data_in(din0), .byte_idx(idx0), .cle(cle0), .ale(ale0),
    .we_n(we_n0), .io_out(io0), .io_oe(oe0), .busy(busy0), .done(done0),
    .aborted(abt0)
  );

  latch_sequencer #(
    .DATA_W(8), .MAX_CYCLES(5), .T_WP(1), .T_WH(3), .T_CLH(2), .T_ALH(4)
  ) u_dut1 (
    .clk(clk), .nreset(nreset), .activate(act1), .mode(mode1), .n_cycles(ncy1),
    .abort(abort1), .data_in(din1), .byte_idx(idx1), .cle(cle1), .ale(ale1),
    .we_n(we_n1), .io_out(io1), .io_oe(oe1), .busy(busy1), .done(done1),
    .aborted(abt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic c, input logic a, input logic w,
                              input logic oe, input logic b, input logic d,
                              input logic ab, input int idx, input logic [7:0] io);
    obs_t o;
    o.cle = c; o.ale = a; o.we_n = w; o.io_oe = oe; o.busy = b;
    o.done = d; o.aborted = ab; o.idx = 3'(idx); o.io = io;
    return o;
  endfunction

  function automatic obs_t idle_obs(input logic d, input logic ab);
    return mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, d, ab, 0, 8'h00);
  endfunction

  task automatic push(input int which, input obs_t o);
    if (which == 0) exp0.push_back(o);
    else exp1.push_back(o);
  endtask

  task automatic flush(input int which);
    if (which == 0) exp0.delete();
    else exp1.delete();
  endtask

  // Expected cycle-by-cycle timeline of one accepted request.
  task automatic schedule(input int which, input logic m, input int n);
    int ne, twp, twh, thold;
    logic [7:0] b [8];
    ne    = (n > 5) ? 5 : n;
    twp   = (which == 0) ? 2 : 1;
    twh   = (which == 0) ? 2 : 3;
    thold = (which == 0) ? 2 : (m ? 4 : 2);
    for (int i = 0; i < 8; i++) b[i] = (which == 0) ? bytes0[i] : bytes1[i];
    for (int i = 0; i < ne; i++) begin
      for (int c = 0; c < twp; c++) push(which, mk(~m, m, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, i, b[i]));
      if (i < ne - 1)
        for (int c = 0; c < twh; c++) push(which, mk(~m, m, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, i + 1, b[i]));
    end
    for (int c = 0; c < thold; c++) push(which, mk(~m, m, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ne - 1, b[ne-1]));
    push(which, idle_obs(1'b1, 1'b0));
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic cmp_obs(input int which, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL dut%0d_cycle t=%0t got cle=%b ale=%b we_n=%b oe=%b busy=%b done=%b abt=%b idx=%0d io=%h expected cle=%b ale=%b we_n=%b oe=%b busy=%b done=%b abt=%b idx=%0d io=%h",
               which, $time, a.cle, a.ale, a.we_n, a.io_oe, a.busy, a.done, a.aborted, a.idx, a.io,
               e.cle, e.ale, e.we_n, e.io_oe, e.busy, e.done, e.aborted, e.idx, e.io);
    end
  endtask

  task automatic stats(input int w, input logic b, input logic wn, input logic d, input logic ab);
    if (b) busy_run[w]++;
    if (b && !wn && prev_we_n[w]) pulse_run[w]++;
    if (!b && prev_busy[w]) begin
      last_busy[w]   = busy_run[w];
      last_pulses[w] = pulse_run[w];
      busy_run[w]    = 0;
      pulse_run[w]   = 0;
    end
    if (d) done_cnt[w]++;
    if (ab) abt_cnt[w]++;
    prev_busy[w] = b;
    prev_we_n[w] = wn;
  endtask

  // Single compare point on the falling edge.
  always @(negedge clk) begin : compare
    obs_t a, e;
    if (nreset) begin
      a = {cle0, ale0, we_n0, oe0, busy0, done0, abt0, idx0, io0};
      e = (exp0.size() > 0) ? exp0.pop_front() : idle_obs(1'b0, 1'b0);
      cmp_obs(0, a, e);
      stats(0, busy0, we_n0, done0, abt0);
      a = {cle1, ale1, we_n1, oe1, busy1, done1, abt1, idx1, io1};
      e = (exp1.size() > 0) ? exp1.pop_front() : idle_obs(1'b0, 1'b0);
      cmp_obs(1, a, e);
      stats(1, busy1, we_n1, done1, abt1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int which, input logic m, input int n, input bit accept);
    if (which == 0) begin act0 = 1'b1; mode0 = m; ncy0 = 3'(n); end
    else            begin act1 = 1'b1; mode1 = m; ncy1 = 3'(n); end
    tick();
    act0 = 1'b0;
    act1 = 1'b0;
    if (accept) schedule(which, m, n);
  endtask

  task automatic do_abort(input int which);
    if (which == 0) abort0 = 1'b1;
    else abort1 = 1'b1;
    tick();
    abort0 = 1'b0;
    abort1 = 1'b0;
    flush(which);
    push(which, idle_obs(1'b0, 1'b1));
  endtask

  task automatic wait_done(input int which, input string name);
    int budget;
    budget = 200;
    while (((which == 0) ? exp0.size() : exp1.size()) > 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: model queue not drained after 200 cycles", name);
      flush(which);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0;
    checks = 0; failures = 0;
    for (int w = 0; w < 2; w++) begin
      busy_run[w] = 0; pulse_run[w] = 0; last_busy[w] = 0; last_pulses[w] = 0;
      done_cnt[w] = 0; abt_cnt[w] = 0; prev_busy[w] = 1'b0; prev_we_n[w] = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin bytes0[i] = 8'h00; bytes1[i] = 8'h00; end
    act0 = 0; mode0 = 0; ncy0 = 0; abort0 = 0;
    act1 = 0; mode1 = 0; ncy1 = 0; abort1 = 0;
    nreset = 1'b1;
    #2 nreset = 1'b0;
    repeat (3) tick();
    chk("reset_we_n", int'(we_n0), 1);
    chk("reset_busy", int'(busy0), 0);
    nreset = 1'b1;
    repeat (2) tick();

    // Command byte with default timing.
    bytes0[0] = 8'h90;
    start(0, 1'b0, 1, 1'b1);
    chk("cmd_first_cle", int'(cle0), 1);
    chk("cmd_first_we_n", int'(we_n0), 0);
    chk("cmd_first_io", int'(io0), 'h90);
    wait_done(0, "cmd");
    chk("cmd_busy_len", last_busy[0], 4);
    chk("cmd_pulses", last_pulses[0], 1);

    // Five-byte address; a second activate while busy is ignored.
    bytes0[0] = 8'h11; bytes0[1] = 8'h22; bytes0[2] = 8'h33; bytes0[3] = 8'h44; bytes0[4] = 8'h55;
    start(0, 1'b1, 5, 1'b1);
    chk("addr_first_ale", int'(ale0), 1);
    chk("addr_first_cle", int'(cle0), 0);
    tick();
    start(0, 1'b0, 2, 1'b0);
    wait_done(0, "addr5");
    chk("addr5_busy_len", last_busy[0], 20);
    chk("addr5_pulses", last_pulses[0], 5);

    // Length 7 clamps to 5.
    start(0, 1'b1, 7, 1'b1);
    wait_done(0, "clamp");
    chk("clamp_busy_len", last_busy[0], 20);
    chk("clamp_pulses", last_pulses[0], 5);

    // Zero length is ignored.
    d0 = done_cnt[0];
    start(0, 1'b0, 0, 1'b0);
    repeat (3) tick();
    chk("zero_no_busy", int'(busy0), 0);
    chk("zero_no_done", done_cnt[0], d0);

    // Abort in the second WE_LOW of a 3-byte address burst.
    bytes0[0] = 8'hA1; bytes0[1] = 8'hA2; bytes0[2] = 8'hA3;
    d0 = done_cnt[0];
    start(0, 1'b1, 3, 1'b1);
    repeat (4) tick();
    chk("abort_pre_we_n", int'(we_n0), 0);
    chk("abort_pre_io", int'(io0), 'hA2);
    do_abort(0);
    chk("abort_aborted", int'(abt0), 1);
    chk("abort_we_n", int'(we_n0), 1);
    chk("abort_ale", int'(ale0), 0);
    chk("abort_oe", int'(oe0), 0);
    repeat (6) tick();
    chk("abort_no_done", done_cnt[0], d0);

    // Abort on the HOLD expiry cycle wins over done.
    bytes0[0] = 8'h70;
    d0 = done_cnt[0];
    start(0, 1'b0, 1, 1'b1);
    repeat (3) tick();
    do_abort(0);
    chk("hold_abort_aborted", int'(abt0), 1);
    chk("hold_abort_done", int'(done0), 0);
    repeat (3) tick();
    chk("hold_abort_no_done", done_cnt[0], d0);

    // Asynchronous reset during WE_LOW.
    d0 = done_cnt[0];
    bytes0[0] = 8'h31; bytes0[1] = 8'h32;
    start(0, 1'b0, 2, 1'b1);
    chk("rst_pre_we_n", int'(we_n0), 0);
    nreset = 1'b0;
    #1;
    chk("rst_async_we_n", int'(we_n0), 1);
    chk("rst_async_busy", int'(busy0), 0);
    chk("rst_async_oe", int'(oe0), 0);
    chk("rst_async_cle", int'(cle0), 0);
    flush(0);
    flush(1);
    prev_busy[0] = 1'b0; busy_run[0] = 0; pulse_run[0] = 0; prev_we_n[0] = 1'b1;
    tick();
    nreset = 1'b1;
    tick();
    bytes0[0] = 8'hFF;
    start(0, 1'b0, 1, 1'b1);
    wait_done(0, "post_rst");
    chk("post_rst_busy_len", last_busy[0], 4);
    chk("rst_no_done", done_cnt[0], d0 + 1);

    // Fast-WE#/long-ALE-hold instance, back-to-back activate in the done cycle.
    bytes1[0] = 8'hC1; bytes1[1] = 8'hC2;
    start(1, 1'b1, 2, 1'b1);
    repeat (8) tick();
    chk("p_busy_last", int'(busy1), 1);
    tick();
    chk("p_done_cycle", int'(done1), 1);
    chk("p_done_busy", int'(busy1), 0);
    bytes1[0] = 8'hE0;
    start(1, 1'b0, 1, 1'b1);
    chk("p_busy_len", last_busy[1], 9);
    chk("p_pulses", last_pulses[1], 2);
    chk("b2b_accept_cle", int'(cle1), 1);
    wait_done(1, "b2b");
    chk("b2b_busy_len", last_busy[1], 3);

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
